// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns the fetch-stage pc/ce request into a single
// SRAM-like bus transaction, stalls fetch until the word arrives, holds the
// word while the pipeline is stalled, and drops data belonging to a
// redirected (flushed) fetch.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing requested yet, waiting for ce after reset
// REQ   | request presented on the bus, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok
// HOLD  | instruction word held on inst_o until the pipeline takes it
module inst_fetch_bridge #(
  parameter int WIDTH    = 32,
  parameter int KSEG_MAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic             ce,
  input  logic             stall_ext,
  input  logic             flush,
  output logic             stall_fetch,
  output logic [WIDTH-1:0] inst_o,
  output logic             inst_valid,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state;
  logic             discard;
  logic             pend;
  logic [WIDTH-1:0] addr_lat;
  logic [WIDTH-1:0] pc_phys;

  // kseg0/kseg1 (top bits 10x) fold onto the low 512 MB physical window
  always_comb begin
    pc_phys = pc;
    if ((KSEG_MAP != 0) && (pc[WIDTH-1 -: 2] == 2'b10)) begin
      pc_phys[WIDTH-1 -: 3] = 3'b000;
    end
  end

  // Once the request has been presented, the latched copy keeps the address
  // stable even if the PC register moves underneath it.
  assign inst_req    = (state == REQ);
  assign inst_addr   = (state == REQ) ? (pend ? addr_lat : pc_phys) : '0;
  assign inst_valid  = (state == HOLD) & ~flush;
  // Gated by reset so every output reads zero while reset is held.
  assign stall_fetch = rst & ce & (state != HOLD) & ~flush;

  // Fetch sequencing: one outstanding transaction, stale data dropped on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      discard  <= 1'b0;
      pend     <= 1'b0;
      addr_lat <= '0;
      inst_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ce) state <= REQ;
        end
        REQ: begin
          if (flush) discard <= 1'b1;
          if (inst_addr_ok) begin
            pend  <= 1'b0;
            state <= WAIT;
          end else if (!pend) begin
            pend     <= 1'b1;
            addr_lat <= pc_phys;
          end
        end
        WAIT: begin
          if (inst_data_ok) begin
            if (discard || flush) begin
              // data belongs to the pre-redirect PC; refetch at the new one
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              inst_o <= inst_rdata;
              state  <= HOLD;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || !stall_ext) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge. A behavioural bus slave with
// programmable addr_ok/data_ok delays serves reads from a synthetic memory;
// expected bus addresses and delivered instructions are queued as stimulus
// is applied and checked as the DUT produces them.
module tb_inst_fetch_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic        stall_ext;
  logic        flush;
  logic        stall_fetch;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];

  // slave controls
  int          addr_delay = 0;
  int          data_delay = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_val = 32'h0;

  inst_fetch_bridge #(.WIDTH(32), .KSEG_MAP(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ce           (ce),
    .stall_ext    (stall_ext),
    .flush        (flush),
    .stall_fetch  (stall_fetch),
    .inst_o       (inst_o),
    .inst_valid   (inst_valid),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a ^ 32'h3bc8_0001;
  endfunction

  function automatic logic [31:0] xlate(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    if (v[31:29] == 3'b100 || v[31:29] == 3'b101) r = {3'b000, v[28:0]};
    return r;
  endfunction

  // queue one fetch: expected bus address and, optionally, the delivered word
  task automatic expect_fetch(input logic [31:0] vaddr, input bit delivered);
    exp_addr_q.push_back(xlate(vaddr));
    if (delivered) exp_inst_q.push_back(mem_of(xlate(vaddr)));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
      else nxt();
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  // bus slave: acts 2 time units after each rising edge
  always begin : slave
    bit          out_pend;
    int          acnt;
    int          dcnt;
    int          dlat;
    logic [31:0] out_addr;
    out_pend = 0; acnt = 0; dcnt = 0; dlat = 0; out_addr = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (!rst) begin
        out_pend = 0; acnt = 0; dcnt = 0;
      end else if (out_pend) begin
        if (dcnt >= dlat) begin
          inst_data_ok = 1'b1;
          inst_rdata   = ovr_en ? ovr_val : mem_of(out_addr);
          ovr_en       = 1'b0;
          out_pend     = 0;
        end else begin
          dcnt++;
        end
      end else if (inst_req) begin
        if (acnt >= addr_delay) begin
          inst_addr_ok = 1'b1;
          acnt     = 0;
          out_pend = 1;
          dcnt     = 0;
          dlat     = data_delay;
          out_addr = inst_addr;
          check_eq("req_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
          if (exp_addr_q.size() != 0) check_eq("bus_addr", inst_addr, exp_addr_q.pop_front());
        end else begin
          acnt++;
        end
      end
    end
  end

  // delivered-instruction scoreboard; a word is consumed when stall_ext is low
  always @(negedge clk) begin
    if (rst && inst_valid) begin
      check_eq("valid_expected", {31'd0, exp_inst_q.size() != 0}, 32'd1);
      if (exp_inst_q.size() != 0) begin
        check_eq("inst_o", inst_o, exp_inst_q[0]);
        if (!stall_ext) void'(exp_inst_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ce = 1'b0; pc = '0; stall_ext = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_req",   {31'd0, inst_req},    32'd0);
    check_eq("rst_addr",  inst_addr,            32'd0);
    check_eq("rst_valid", {31'd0, inst_valid},  32'd0);
    check_eq("rst_inst",  inst_o,               32'd0);
    check_eq("rst_stall", {31'd0, stall_fetch}, 32'd0);
    nxt();
    rst = 1'b1;

    // 1: basic fetch, immediate handshakes, 3-cycle latency
    ce = 1'b1; pc = 32'hbfc0_0000;
    exp_addr_q.push_back(32'h1fc0_0000);
    exp_inst_q.push_back(32'h2408_0001);
    @(negedge clk);
    check_eq("t1_idle_req",   {31'd0, inst_req},    32'd0);
    check_eq("t1_idle_stall", {31'd0, stall_fetch}, 32'd1);
    nxt();
    @(negedge clk);
    check_eq("t1_req",       {31'd0, inst_req},    32'd1);
    check_eq("t1_addr",      inst_addr,            32'h1fc0_0000);
    check_eq("t1_req_stall", {31'd0, stall_fetch}, 32'd1);
    nxt();
    @(negedge clk);
    check_eq("t1_wait_req",   {31'd0, inst_req},    32'd0);
    check_eq("t1_wait_valid", {31'd0, inst_valid},  32'd0);
    check_eq("t1_wait_stall", {31'd0, stall_fetch}, 32'd1);
    nxt();
    @(negedge clk);
    check_eq("t1_hold_valid", {31'd0, inst_valid},  32'd1);
    check_eq("t1_hold_inst",  inst_o,               32'h2408_0001);
    check_eq("t1_hold_stall", {31'd0, stall_fetch}, 32'd0);
    nxt();

    // 2: addr_ok delayed 3 cycles, PC wanders while the request is pending
    addr_delay = 3;
    pc = 32'hbfc0_0004;
    expect_fetch(32'hbfc0_0004, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) pc = 32'hbfc0_0100;
      if (i == 2) pc = 32'h1234_5678;
      if (i == 3) pc = 32'hbfc0_0004;
      @(negedge clk);
      check_eq("t2_req",   {31'd0, inst_req},    32'd1);
      check_eq("t2_addr",  inst_addr,            32'h1fc0_0004);
      check_eq("t2_stall", {31'd0, stall_fetch}, 32'd1);
      nxt();
    end
    addr_delay = 0;
    @(negedge clk);
    check_eq("t2_wait_req",   {31'd0, inst_req},    32'd0);
    check_eq("t2_wait_stall", {31'd0, stall_fetch}, 32'd1);
    nxt();

    // 3: HOLD under external stall for 4 cycles
    stall_ext = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t3_valid", {31'd0, inst_valid}, 32'd1);
      check_eq("t3_inst",  inst_o,              mem_of(32'h1fc0_0004));
      check_eq("t3_noreq", {31'd0, inst_req},   32'd0);
      nxt();
    end
    stall_ext = 1'b0;
    @(negedge clk);
    check_eq("t3_release_valid", {31'd0, inst_valid}, 32'd1);
    check_eq("t3_release_noreq", {31'd0, inst_req},   32'd0);
    nxt();

    // 4: flush in WAIT; stale data (0xdeadbeef) must be dropped
    data_delay = 2;
    pc = 32'hbfc0_0008;
    expect_fetch(32'hbfc0_0008, 1'b0);
    @(negedge clk);
    check_eq("t4_req", {31'd0, inst_req}, 32'd1);
    nxt();
    flush = 1'b1; ovr_en = 1'b1; ovr_val = 32'hdead_beef;
    @(negedge clk);
    check_eq("t4_flush_stall", {31'd0, stall_fetch}, 32'd0);
    check_eq("t4_flush_valid", {31'd0, inst_valid},  32'd0);
    nxt();
    flush = 1'b0; pc = 32'hbfc0_0380; data_delay = 0;
    expect_fetch(32'hbfc0_0380, 1'b1);
    @(negedge clk);
    check_eq("t4_still_wait", {31'd0, inst_req}, 32'd0);
    nxt();
    @(negedge clk);
    check_eq("t4_stale_valid", {31'd0, inst_valid}, 32'd0);
    nxt();
    @(negedge clk);
    check_eq("t4_refetch_req",  {31'd0, inst_req}, 32'd1);
    check_eq("t4_refetch_addr", inst_addr,         32'h1fc0_0380);
    nxt();
    nxt();
    @(negedge clk);
    check_eq("t4_valid", {31'd0, inst_valid}, 32'd1);
    nxt();

    // 5a: flush coincident with data_ok
    pc = 32'hbfc0_0384;
    expect_fetch(32'hbfc0_0384, 1'b0);
    @(negedge clk);
    check_eq("t5a_req", {31'd0, inst_req}, 32'd1);
    nxt();
    flush = 1'b1;
    @(negedge clk);
    check_eq("t5a_data_ok",   {31'd0, inst_data_ok}, 32'd1);
    check_eq("t5a_valid",     {31'd0, inst_valid},   32'd0);
    check_eq("t5a_stall",     {31'd0, stall_fetch},  32'd0);
    nxt();
    flush = 1'b0; pc = 32'hbfc0_0200;
    expect_fetch(32'hbfc0_0200, 1'b1);
    @(negedge clk);
    check_eq("t5a_redir_req",  {31'd0, inst_req}, 32'd1);
    check_eq("t5a_redir_addr", inst_addr,         32'h1fc0_0200);
    nxt();
    stall_ext = 1'b1;
    nxt();
    @(negedge clk);
    check_eq("t5b_hold_valid", {31'd0, inst_valid}, 32'd1);
    nxt();

    // 5b: flush in HOLD withdraws the held word
    flush = 1'b1;
    @(negedge clk);
    check_eq("t5b_flush_valid", {31'd0, inst_valid}, 32'd0);
    nxt();
    void'(exp_inst_q.pop_front());
    flush = 1'b0; stall_ext = 1'b0; pc = 32'hbfc0_0300;
    expect_fetch(32'hbfc0_0300, 1'b1);
    @(negedge clk);
    check_eq("t5b_redir_req",  {31'd0, inst_req}, 32'd1);
    check_eq("t5b_redir_addr", inst_addr,         32'h1fc0_0300);
    nxt();
    nxt();
    @(negedge clk);
    check_eq("t5b_valid", {31'd0, inst_valid}, 32'd1);
    nxt();

    // 6: asynchronous reset while waiting for data
    data_delay = 3;
    pc = 32'hbfc0_0304;
    expect_fetch(32'hbfc0_0304, 1'b0);
    @(negedge clk);
    check_eq("t6_req", {31'd0, inst_req}, 32'd1);
    nxt();
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_req",   {31'd0, inst_req},    32'd0);
    check_eq("t6_rst_addr",  inst_addr,            32'd0);
    check_eq("t6_rst_valid", {31'd0, inst_valid},  32'd0);
    check_eq("t6_rst_inst",  inst_o,               32'd0);
    check_eq("t6_rst_stall", {31'd0, stall_fetch}, 32'd0);
    nxt();
    ce = 1'b0; data_delay = 0;
    nxt();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t6_idle_req", {31'd0, inst_req}, 32'd0);
      nxt();
    end

    // translation corners: kseg0 folds, kseg2 passes through
    ce = 1'b1; pc = 32'h8000_1000;
    expect_fetch(32'h8000_1000, 1'b1);
    wait_valid("kseg0_valid");
    nxt();
    pc = 32'hc000_0010;
    expect_fetch(32'hc000_0010, 1'b1);
    wait_valid("kseg2_valid");
    nxt();
    rst = 1'b0;
    nxt();
    check_eq("addr_q_drained", exp_addr_q.size(), 32'd0);
    check_eq("inst_q_drained", exp_inst_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
